// File: rtl/sram_wait_responder.sv
// Byte-addressed memory responder with programmable wait states.
// clk, reset_n | re, we, addr, datafrommif in | datatomif, mem_resp, busy, err out.
module sram_wait_responder #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       datafrommif,
  output logic [7:0]        datatomif,
  output logic              mem_resp,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_RD, S_WR_LO,
    S_WR_HI, S_RESP, S_ERR
  } state_t;

  localparam logic [3:0] WLOAD =
    (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              armed_q, armed_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       data_q, data_d;
  logic [7:0]        dout_q, dout_d;
  logic [ADDR_W-1:0] addr_hi;

  logic [7:0] mem [2**ADDR_W];

  // high byte address wraps naturally at the array end
  assign addr_hi = addr_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dout_d  = dout_q;
    unique case (state_q)
      S_IDLE: begin
        // re-arm only once the requester drops both strobes
        if (!re && !we) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          armed_d = 1'b0;
          if (re && we) begin
            state_d = S_ERR;
          end else begin
            addr_d = addr;
            wr_d   = we;
            if (we) data_d = datafrommif;
            if (WAIT_CYCLES == 0) begin
              state_d = we ? S_WR_LO : S_RD;
            end else begin
              state_d = S_WAIT;
              cnt_d   = WLOAD;
            end
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = wr_q ? S_WR_LO : S_RD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD: begin
        dout_d  = mem[addr_q];
        state_d = S_RESP;
      end
      S_WR_LO: state_d = S_WR_HI;
      S_WR_HI: state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      armed_q <= 1'b1;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= 16'h0000;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dout_q  <= dout_d;
    end
  end

  // array is never reset; writes are keyed off the state flops only
  always_ff @(posedge clk) begin
    if (state_q == S_WR_LO) begin
      mem[addr_q] <= data_q[7:0];
    end else if (state_q == S_WR_HI) begin
      mem[addr_hi] <= data_q[15:8];
    end
  end

  assign datatomif = dout_q;
  assign mem_resp  = (state_q == S_RESP) ||
                     (state_q == S_ERR);
  assign err       = (state_q == S_ERR);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_sram_wait_responder.sv
// Directed bench for sram_wait_responder (WAIT_CYCLES=2 and 0).
// Read data scoreboarded through a queue; latency counted per request.
module tb_sram_wait_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        re0, we0, re1, we1;
  logic [13:0] addr0, addr1;
  logic [15:0] din0, din1;
  logic [7:0]  dout0, dout1;
  logic        resp0, busy0, err0;
  logic        resp1, busy1, err1;

  sram_wait_responder #(.ADDR_W(14), .WAIT_CYCLES(2)) u_d0 (
    .clk(clk), .reset_n(reset_n), .re(re0), .we(we0),
    .addr(addr0), .datafrommif(din0), .datatomif(dout0),
    .mem_resp(resp0), .busy(busy0), .err(err0)
  );

  sram_wait_responder #(.ADDR_W(14), .WAIT_CYCLES(0)) u_d1 (
    .clk(clk), .reset_n(reset_n), .re(re1), .we(we1),
    .addr(addr1), .datafrommif(din1), .datatomif(dout1),
    .mem_resp(resp1), .busy(busy1), .err(err1)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] sbq [$];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic txn(input bit sel,
                     input logic r, input logic w,
                     input logic [13:0] a,
                     input logic [15:0] d,
                     input int lat,
                     input logic xerr,
                     input logic [7:0] xd,
                     input string tag);
    int got;
    int nr;
    logic rs, bs, es;
    logic [7:0] ds;
    if (sel) begin
      re1 = r; we1 = w; addr1 = a; din1 = d;
    end else begin
      re0 = r; we0 = w; addr0 = a; din0 = d;
    end
    if (r && !w) sbq.push_back(xd);
    got = -1;
    nr  = 0;
    for (int n = 0; n < lat + 3; n++) begin
      tick;
      re0 = 1'b0; we0 = 1'b0;
      re1 = 1'b0; we1 = 1'b0;
      rs = sel ? resp1 : resp0;
      bs = sel ? busy1 : busy0;
      es = sel ? err1  : err0;
      ds = sel ? dout1 : dout0;
      if (rs) begin
        nr++;
        if (got < 0) got = n;
        chk({tag, " err"}, 32'(es), 32'(xerr));
        if (r && !w && sbq.size() > 0)
          chk({tag, " data"}, 32'(ds), 32'(sbq.pop_front()));
      end else if (got < 0) begin
        chk({tag, " busy"}, 32'(bs), 32'd1);
      end
    end
    chk({tag, " lat"}, 32'(got), 32'(lat));
    chk({tag, " nresp"}, 32'(nr), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int nr;
    reset_n = 1'b0;
    re0 = 0; we0 = 0; addr0 = '0; din0 = '0;
    re1 = 0; we1 = 0; addr1 = '0; din1 = '0;
    tick; tick; tick;
    chk("rst resp0", 32'(resp0), 32'd0);
    chk("rst dout0", 32'(dout0), 32'd0);
    chk("rst busy0", 32'(busy0), 32'd0);
    chk("rst err0",  32'(err0),  32'd0);
    chk("rst resp1", 32'(resp1), 32'd0);
    chk("rst dout1", 32'(dout1), 32'd0);
    chk("rst busy1", 32'(busy1), 32'd0);
    chk("rst err1",  32'(err1),  32'd0);
    reset_n = 1'b1;
    tick;

    // basic write / read, little-endian split
    txn(0, 0, 1, 14'h0100, 16'hBEEF, 4, 0, 8'h00, "wr beef");
    txn(0, 1, 0, 14'h0100, 16'h0000, 3, 0, 8'hEF, "rd 0100");
    txn(0, 1, 0, 14'h0101, 16'h0000, 3, 0, 8'hBE, "rd 0101");

    // high byte wraps to address 0
    txn(0, 0, 1, 14'h3FFF, 16'h1234, 4, 0, 8'h00, "wr 3fff");
    txn(0, 1, 0, 14'h3FFF, 16'h0000, 3, 0, 8'h34, "rd 3fff");
    txn(0, 1, 0, 14'h0000, 16'h0000, 3, 0, 8'h12, "rd 0000");

    // simultaneous re/we is an error, no side effects
    txn(0, 0, 1, 14'h0200, 16'h0055, 4, 0, 8'h00, "wr 0200");
    txn(0, 1, 1, 14'h0200, 16'hFFFF, 0, 1, 8'h00, "err");
    chk("err dout kept", 32'(dout0), 32'h12);
    txn(0, 1, 0, 14'h0200, 16'h0000, 3, 0, 8'h55, "rd 0200");

    // re held high: a single response only
    re0 = 1'b1; addr0 = 14'h0100;
    sbq.push_back(8'hEF);
    nr = 0;
    for (int n = 0; n < 20; n++) begin
      tick;
      if (resp0) begin
        nr++;
        if (sbq.size() > 0)
          chk("hold data", 32'(dout0), 32'(sbq.pop_front()));
      end
    end
    chk("hold nresp", 32'(nr), 32'd1);
    re0 = 1'b0;
    tick;
    txn(0, 1, 0, 14'h0101, 16'h0000, 3, 0, 8'hBE, "rearm");

    // toggling we while busy is ignored
    re0 = 1'b1; addr0 = 14'h0100; din0 = 16'h0000;
    sbq.push_back(8'hEF);
    nr = 0;
    for (int n = 0; n < 10; n++) begin
      tick;
      re0 = 1'b0;
      we0 = (n < 3) && (n % 2 == 0);
      if (resp0) begin
        nr++;
        if (sbq.size() > 0)
          chk("tgl data", 32'(dout0), 32'(sbq.pop_front()));
      end
    end
    we0 = 1'b0;
    chk("tgl nresp", 32'(nr), 32'd1);
    tick;
    txn(0, 1, 0, 14'h0100, 16'h0000, 3, 0, 8'hEF, "tgl mem");

    // reset during WAIT: nothing written
    txn(0, 0, 1, 14'h0010, 16'h0000, 4, 0, 8'h00, "wr 0010");
    we0 = 1'b1; addr0 = 14'h0010; din0 = 16'hA5A5;
    tick;
    we0 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstw busy", 32'(busy0), 32'd0);
    nr = 0;
    for (int n = 0; n < 3; n++) begin
      tick;
      if (resp0) nr++;
    end
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick;
      if (resp0) nr++;
    end
    chk("rstw nresp", 32'(nr), 32'd0);
    txn(0, 1, 0, 14'h0010, 16'h0000, 3, 0, 8'h00, "rstw lo");
    txn(0, 1, 0, 14'h0011, 16'h0000, 3, 0, 8'h00, "rstw hi");

    // reset in WR_HI: low byte only
    we0 = 1'b1; addr0 = 14'h0010; din0 = 16'hA5A5;
    tick;
    we0 = 1'b0;
    tick; tick; tick;
    reset_n = 1'b0;
    #1;
    chk("rsth busy", 32'(busy0), 32'd0);
    nr = 0;
    for (int n = 0; n < 3; n++) begin
      tick;
      if (resp0) nr++;
    end
    reset_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      tick;
      if (resp0) nr++;
    end
    chk("rsth nresp", 32'(nr), 32'd0);
    txn(0, 1, 0, 14'h0010, 16'h0000, 3, 0, 8'hA5, "rsth lo");
    txn(0, 1, 0, 14'h0011, 16'h0000, 3, 0, 8'h00, "rsth hi");

    // zero wait states
    txn(1, 0, 1, 14'h0005, 16'hC35A, 2, 0, 8'h00, "w0 wr");
    txn(1, 1, 0, 14'h0005, 16'h0000, 1, 0, 8'h5A, "w0 rd lo");
    txn(1, 1, 0, 14'h0006, 16'h0000, 1, 0, 8'hC3, "w0 rd hi");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_wait_responder.md
Name: sram_wait_responder

Overview:
Memory-side responder for the memory-interface request protocol: accepts single-cycle read/write requests and answers each with a one-cycle mem_resp pulse. Contains a byte-addressed array.
- Write: 16-bit data, stored little-endian over two consecutive bytes.
- Read: returns one byte.
- Programmable wait states model slow memory, which stresses the requester's handshake.

Parameters:
ADDR_W, 14, byte-address width; array depth is 2**ADDR_W bytes.
WAIT_CYCLES, 2, wait-state cycles inserted before every access; legal range 0..15.

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
re  input  1  read request from requester
we  input  1  write request from requester
addr  input  ADDR_W  byte address, sampled on the accepting edge
datafrommif  input  16  write data, sampled on the accepting edge; [7:0] goes to addr, [15:8] to addr+1
datatomif  output  8  read data, valid from the mem_resp cycle until the next completed read
mem_resp  output  1  one-cycle completion pulse for every accepted request
busy  output  1  high in every state except IDLE
err  output  1  one-cycle pulse when re and we are sampled high together

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - Outputs: mem_resp=0, datatomif=8'h00, busy=0, err=0.
  - Wait counter = 0; armed = 1.
  - Array contents are not reset: they are retained across reset and undefined at power-up.
- Arming: requests are accepted only in IDLE with armed=1. Accepting a request clears armed. Armed sets again on any IDLE cycle where re=0 and we=0. This lets the requester hold re/we level until it sees mem_resp without triggering a duplicate access.
- FSM states: IDLE, WAIT, RD, WR_LO, WR_HI, RESP, ERR.
- IDLE with armed=1:
  - re&we → ERR.
  - we only → latch addr and data; go to WAIT (counter=WAIT_CYCLES-1), or to WR_LO if WAIT_CYCLES=0.
  - re only → latch addr; go to WAIT, or to RD if WAIT_CYCLES=0.
- WAIT: decrement counter each cycle; at 0, go to RD or WR_LO according to the latched op.
- RD: datatomif <= mem[addr_l]; go to RESP.
- WR_LO: mem[addr_l] <= data_l[7:0]; go to WR_HI.
- WR_HI: mem[addr_l+1] <= data_l[15:8], with the address wrapping modulo 2**ADDR_W (all-ones → 0); go to RESP.
- RESP: mem_resp=1 for exactly this cycle; go to IDLE.
- ERR: err=1 and mem_resp=1 for this cycle; array and datatomif unchanged; go to IDLE.
- Outputs mem_resp, err and busy are registered (decoded from state flops). There is no combinational path from inputs to outputs.
- Latency, counted from the accepting edge E0:
  - Read: mem_resp is high in the cycle after edge E0+WAIT_CYCLES+1.
  - Write: mem_resp is high in the cycle after edge E0+WAIT_CYCLES+2.
  - Error: mem_resp and err are high in the cycle after E0.
- Requests arriving while busy=1 are ignored and are not queued.
- A request arriving in the RESP cycle itself is ignored. Because armed=0 at that point, the next acceptance requires at least one IDLE cycle with re=we=0.
- Reset mid-operation: the operation is abandoned and no mem_resp is issued.
  - Reset before WR_LO completes: neither byte is written.
  - Reset after WR_LO but before WR_HI: only the low byte is written (defined behaviour).
- Address and data are taken only from the latched copies; input changes after acceptance have no effect.

Test Plan:
- WAIT_CYCLES=2. Write 16'hBEEF to 0x0100 → mem_resp exactly 4 cycles after accept, busy high throughout. Read 0x0100 → datatomif=8'hEF with mem_resp 3 cycles after accept. Read 0x0101 → 8'hBE.
- Write 16'h1234 to 0x3FFF → read 0x3FFF=8'h34, read 0x0000=8'h12 (address wrap).
- re=we=1 at 0x0200, which holds 8'h55 → err and mem_resp pulse together one cycle after accept. A following read of 0x0200 returns 8'h55; datatomif is unchanged by the error.
- re held high for 20 cycles → exactly one mem_resp. Drop re for one cycle and reassert → a second mem_resp. Toggle we while busy → no extra response and memory unchanged.
- Assert reset_n=0 during WAIT of a write of 16'hA5A5 to 0x0010, which holds 16'h0000 → no mem_resp; reading 0x0010/0x0011 returns 8'h00/8'h00. Repeat with reset asserted in WR_HI → 0x0010=8'hA5, 0x0011=8'h00.
- WAIT_CYCLES=0 build: write then read 0x0005 back-to-back with one idle cycle between → write response 2 cycles after accept, read response 1 cycle after accept, data matches.
